fifo_burst_reader: RTL

- Read-side controller for the team's synchronous FIFO (1-cycle read latency, rden/empty/rddata interface).
- On a start command it drains a programmed number of words and presents them on a valid/ready stream, with a last-beat marker and a done pulse.
- Sits between the FIFO and downstream consumers. A 2-entry skid buffer gives 1 beat/cycle throughput under backpressure.

---
 rtl/fifo_burst_reader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Drains a programmed burst from a 1-cycle-latency FIFO onto a valid/ready stream with last marker and done pulse.
// Latency: first m_valid two cycles after the first fifo_rden; one beat per cycle sustained.
// Backpressure: 2-entry skid buffer; reads stop once buffered plus in-flight words would exceed two.
module fifo_burst_reader #(
    parameter int WIDTH = 128,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             fifo_rden,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rddata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q,      state_d;
    logic [LEN_W-1:0]       len_q,        len_d;
    logic [LEN_W-1:0]       req_cnt_q,    req_cnt_d;
    logic [LEN_W-1:0]       out_cnt_q,    out_cnt_d;
    logic                   inflight_q,   inflight_d;
    logic                   infl_last_q,  infl_last_d;
    logic [1:0]             buf_cnt_q,    buf_cnt_d;
    logic [1:0][WIDTH-1:0]  buf_dat_q,    buf_dat_d;
    logic [1:0]             buf_lst_q,    buf_lst_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;

    logic                   pop;
    logic [2:0]             occ;
    logic [1:0]             cnt_after_pop;
    logic                   rden;

    // Next-state: burst sequencing, read issue and skid-buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        req_cnt_d   = req_cnt_q;
        out_cnt_d   = out_cnt_q;
        buf_dat_d   = buf_dat_q;
        buf_lst_d   = buf_lst_q;
        done_d      = 1'b0;

        pop  = (buf_cnt_q != 2'd0) && m_ready;
        // Occupancy after this cycle's pop; a new read only fits if at most one slot is claimed.
        occ  = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
        rden = (state_q == RUN) && !fifo_empty && (req_cnt_q < len_q) && (occ <= 3'd1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        state_d   = RUN;
                        len_d     = burst_len;
                        req_cnt_d = '0;
                        out_cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rden) begin
                    req_cnt_d = req_cnt_q + 1'b1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                    if (out_cnt_q == len_q - 1'b1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);

        // The last flag travels with the read so it is attached when the word lands.
        inflight_d  = rden;
        infl_last_d = rden && (req_cnt_q == len_q - 1'b1);

        // Head is always entry 0; a pop shifts entry 1 forward.
        if (pop) begin
            buf_dat_d[0] = buf_dat_q[1];
            buf_lst_d[0] = buf_lst_q[1];
        end
        cnt_after_pop = buf_cnt_q - 2'(pop);
        if (inflight_q) begin
            buf_dat_d[cnt_after_pop[0]] = fifo_rddata;
            buf_lst_d[cnt_after_pop[0]] = infl_last_q;
        end
        buf_cnt_d = cnt_after_pop + 2'(inflight_q);
    end

    // State registers with synchronous active-low reset; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            len_q       <= '0;
            req_cnt_q   <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            buf_cnt_q   <= '0;
            buf_dat_q   <= '0;
            buf_lst_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            req_cnt_q   <= req_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            buf_cnt_q   <= buf_cnt_d;
            buf_dat_q   <= buf_dat_d;
            buf_lst_q   <= buf_lst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fifo_rden = rden;
    assign m_valid   = (buf_cnt_q != 2'd0);
    assign m_data    = buf_dat_q[0];
    assign m_last    = (buf_cnt_q != 2'd0) && buf_lst_q[0];

endmodule
